operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/regfile.sv | 29 ++
 rtl/operand_fetch.sv | 86 ++++++++
 tb/tb_operand_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field positions, op/ext encodings, ALU control codes and
// the shared code-to-control decode used by operand fetch and the ALU.
package cpu_pkg;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int EXT_MSB = 7;
  localparam int EXT_LSB = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_REG  = 4'b0000;
  localparam logic [3:0] ENC_AND = 4'b0001;
  localparam logic [3:0] ENC_OR  = 4'b0010;
  localparam logic [3:0] ENC_XOR = 4'b0011;
  localparam logic [3:0] ENC_ADD = 4'b0101;
  localparam logic [3:0] ENC_SUB = 4'b1001;
  localparam logic [3:0] ENC_CMP = 4'b1011;
  localparam logic [3:0] ENC_MOV = 4'b1101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;

  typedef struct packed {
    logic       legal;
    logic [2:0] alucont;
    logic       wen;
    logic       sext;
  } dec_t;

  // Register forms decode ext, immediate forms decode op; both share these codes.
  function automatic dec_t decode(input logic [3:0] code);
    dec_t d;
    d = '{legal: 1'b1, alucont: ALU_ADD, wen: 1'b1, sext: 1'b1};
    case (code)
      ENC_AND: begin d.alucont = ALU_AND; d.sext = 1'b0; end
      ENC_OR:  begin d.alucont = ALU_OR;  d.sext = 1'b0; end
      ENC_XOR: begin d.alucont = ALU_XOR; d.sext = 1'b0; end
      ENC_ADD: d.alucont = ALU_ADD;
      ENC_SUB: d.alucont = ALU_SUB;
      ENC_CMP: begin d.alucont = ALU_CMP; d.wen = 1'b0; end
      ENC_MOV: d.alucont = ALU_MOV;
      default: begin d.legal = 1'b0; d.wen = 1'b0; end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: NREG x WIDTH register file, two asynchronous reads, one synchronous
// write, all entries cleared by asynchronous reset.
module regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [3:0]       rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [WIDTH-1:0] wd
);
  logic [WIDTH-1:0] r_mem [NREG];

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decodes an instruction, reads/bypasses operands and presents
// them to the ALU stage through a one-entry valid/ready output register.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic             wb_en,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rsrc,
  output logic [WIDTH-1:0] out_rdest,
  output logic [2:0]       out_alucont,
  output logic             out_wen,
  output logic [3:0]       out_waddr,
  output logic             illegal
);
  logic [3:0]       w_op, w_rd, w_ext, w_rs, w_code;
  logic [7:0]       w_imm;
  logic             w_reg_form, w_accept, w_load;
  dec_t             w_dec;
  logic [WIDTH-1:0] w_rf_rd, w_rf_rs, w_byp_rd, w_byp_rs, w_imm_ext, w_src;

  assign w_op       = in_instr[OP_MSB:OP_LSB];
  assign w_rd       = in_instr[RD_MSB:RD_LSB];
  assign w_ext      = in_instr[EXT_MSB:EXT_LSB];
  assign w_rs       = in_instr[RS_MSB:RS_LSB];
  assign w_imm      = in_instr[IMM_MSB:IMM_LSB];
  assign w_reg_form = (w_op == OP_REG);
  assign w_code     = w_reg_form ? w_ext : w_op;
  assign w_dec      = decode(w_code);

  regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra_addr (w_rd),
    .ra_data (w_rf_rd),
    .rb_addr (w_rs),
    .rb_data (w_rf_rs),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Same-cycle writeback wins over the stored value so the captured operand is current.
  assign w_byp_rd  = (wb_en && wb_addr == w_rd) ? wb_data : w_rf_rd;
  assign w_byp_rs  = (wb_en && wb_addr == w_rs) ? wb_data : w_rf_rs;
  assign w_imm_ext = w_dec.sext ? WIDTH'($signed(w_imm)) : WIDTH'(w_imm);
  assign w_src     = w_reg_form ? w_byp_rs : w_imm_ext;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && w_dec.legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
      out_rsrc    <= '0;
      out_rdest   <= '0;
      out_alucont <= '0;
      out_wen     <= 1'b0;
      out_waddr   <= '0;
    end else begin
      illegal <= w_accept && !w_dec.legal;
      if (w_load) begin
        out_valid   <= 1'b1;
        out_rsrc    <= w_src;
        out_rdest   <= w_byp_rd;
        out_alucont <= w_dec.alucont;
        out_wen     <= w_dec.wen;
        out_waddr   <= w_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a
// behavioural model built from the instruction table and handshake rules.
module tb_operand_fetch;
  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = '0, wb_data = '0;
  logic [3:0]  wb_addr = '0;
  logic        in_ready, out_valid, out_wen, illegal;
  logic [15:0] out_rsrc, out_rdest;
  logic [2:0]  out_alucont;
  logic [3:0]  out_waddr;
  int          n_tests = 0, n_fail = 0;
  int          codes [7] = '{1, 2, 3, 5, 9, 11, 13};
  int          alus  [7] = '{2, 4, 3, 0, 1, 5, 6};
  logic [15:0] m_rf [16];
  logic        m_valid, m_ill, m_wen;
  logic [15:0] m_src, m_dst;
  logic [2:0]  m_alu;
  logic [3:0]  m_waddr;

  always #5 clk = ~clk;

  operand_fetch #(.WIDTH(16), .NREG(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rsrc(out_rsrc),
    .out_rdest(out_rdest), .out_alucont(out_alucont), .out_wen(out_wen),
    .out_waddr(out_waddr), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_valid = 0; m_ill = 0; m_wen = 0; m_src = 0; m_dst = 0; m_alu = 0; m_waddr = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
  endtask

  task automatic check_all;
    chk("out_valid", out_valid, m_valid);
    chk("illegal", illegal, m_ill);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_rsrc", out_rsrc, m_src);
    chk("out_rdest", out_rdest, m_dst);
    chk("out_alucont", out_alucont, m_alu);
    chk("out_wen", out_wen, m_wen);
    chk("out_waddr", out_waddr, m_waddr);
  endtask

  // One clock: model the edge from the inputs currently driven, then compare.
  task automatic cycle;
    logic        acc;
    logic [15:0] ins;
    logic [3:0]  code;
    int          k;
    ins  = in_instr;
    acc  = in_valid && (!m_valid || out_ready);
    code = (ins[15:12] == 4'h0) ? ins[7:4] : ins[15:12];
    k = -1;
    for (int i = 0; i < 7; i++) if (codes[i] == int'(code)) k = i;
    @(posedge clk); #1;
    m_ill = acc && k < 0;
    if (acc && k >= 0) begin
      m_valid = 1;
      m_dst = (wb_en && wb_addr == ins[11:8]) ? wb_data : m_rf[ins[11:8]];
      if (ins[15:12] == 4'h0) m_src = (wb_en && wb_addr == ins[3:0]) ? wb_data : m_rf[ins[3:0]];
      else m_src = (k < 3) ? {8'h00, ins[7:0]} : {{8{ins[7]}}, ins[7:0]};
      m_alu = 3'(alus[k]);
      m_wen = (code != 4'b1011);
      m_waddr = ins[11:8];
    end else if (out_ready) m_valid = 0;
    if (wb_en) m_rf[wb_addr] = wb_data;
    check_all();
  endtask

  task automatic async_reset;
    in_valid = 0; wb_en = 0;
    #2 reset_n = 0;
    #1 model_reset();
    chk("async_out_valid", out_valid, 0);
    check_all();
    @(posedge clk); #1 reset_n = 1;
    chk("ready_after_reset", in_ready, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    reset_n = 1;
    wb_en = 1; wb_addr = 3; wb_data = 16'h0005; cycle();
    wb_addr = 4; wb_data = 16'h0003; cycle();
    wb_en = 0; in_valid = 1; in_instr = 16'h0354; out_ready = 1; cycle();
    chk("add_valid", out_valid, 1);
    chk("add_rdest", out_rdest, 16'h0005);
    chk("add_rsrc", out_rsrc, 16'h0003);
    chk("add_alu", out_alucont, 3'b000);
    chk("add_wen", out_wen, 1);
    chk("add_waddr", out_waddr, 3);
    in_instr = 16'h52FF; cycle();
    chk("addi_rsrc", out_rsrc, 16'hFFFF);
    in_instr = 16'h12FF; cycle();
    chk("andi_rsrc", out_rsrc, 16'h00FF);
    chk("andi_alu", out_alucont, 3'b010);
    in_instr = 16'h01B2; cycle();
    chk("cmp_alu", out_alucont, 3'b101);
    chk("cmp_wen", out_wen, 0);
    out_ready = 0; in_instr = 16'h0354;
    repeat (3) begin
      cycle();
      chk("hold_alu", out_alucont, 3'b101);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("ready_comb", in_ready, 1);
    cycle();
    chk("after_hold_alu", out_alucont, 3'b000);
    chk("after_hold_rdest", out_rdest, 16'h0005);
    in_instr = 16'h0596; wb_en = 1; wb_addr = 6; wb_data = 16'h1234; cycle();
    chk("bypass_rsrc", out_rsrc, 16'h1234);
    chk("sub_alu", out_alucont, 3'b001);
    wb_en = 0; in_instr = 16'hF000; cycle();
    chk("illegal_pulse", illegal, 1);
    chk("illegal_valid", out_valid, 0);
    in_valid = 0; cycle();
    chk("illegal_clear", illegal, 0);
    in_valid = 1; in_instr = 16'h0354; cycle();
    out_ready = 0;
    chk("pre_reset_valid", out_valid, 1);
    async_reset();
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_instr = {4'h0, 4'(i), 4'h5, 4'(15 - i)}; cycle();
      chk("zero_rdest", out_rdest, 0);
      chk("zero_rsrc", out_rsrc, 0);
    end
    repeat (400) begin
      int k;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en = $urandom_range(0, 1) == 1;
      wb_addr = 4'($urandom);
      wb_data = 16'($urandom);
      k = $urandom_range(0, 6);
      if ($urandom_range(0, 3) != 0)
        in_instr = $urandom_range(0, 1) == 1 ? {4'h0, 4'($urandom), 4'(codes[k]), 4'($urandom)}
                                             : {4'(codes[k]), 4'($urandom), 8'($urandom)};
      else in_instr = 16'($urandom);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
